// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALU_CTRL_W / NUM_REQ / DATA_W : widths and requester count
//   - NOP..SLT                      : ALU opcode encodings
//   - req_t                         : one queued ALU operation
package alu_pkg;

    localparam int ALU_CTRL_W = 5;
    localparam int NUM_REQ    = 2;
    localparam int DATA_W     = 32;

    // Opcodes stay plain constants rather than an enum: values above SLT
    // are legal on the wire and are forwarded untouched.
    localparam logic [ALU_CTRL_W-1:0] NOP = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ADD = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] SUB = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] AND = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] OR  = 5'd4;
    localparam logic [ALU_CTRL_W-1:0] XOR = 5'd5;
    localparam logic [ALU_CTRL_W-1:0] NOR = 5'd6;
    localparam logic [ALU_CTRL_W-1:0] SL  = 5'd7;
    localparam logic [ALU_CTRL_W-1:0] SR  = 5'd8;
    localparam logic [ALU_CTRL_W-1:0] SLT = 5'd9;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic                  sign;
        logic [DATA_W-1:0]     in1;
        logic [DATA_W-1:0]     in2;
    } req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the requesters and the
// ALU arbiter.
//   req_valid/req_ready  : per-requester request handshake
//   req_ctrl/sign/in1/in2: per-requester operation
//   resp_valid/resp_ready: per-requester response handshake
//   resp_out/resp_zero   : shared result bus, owned by the valid requester
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][ALU_CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ-1:0]                 req_sign;
    logic [NUM_REQ-1:0][DATA_W-1:0]     req_in1;
    logic [NUM_REQ-1:0][DATA_W-1:0]     req_in2;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [NUM_REQ-1:0]                 resp_ready;
    logic [DATA_W-1:0]                  resp_out;
    logic                               resp_zero;

    modport master (
        output req_valid, req_ctrl, req_sign, req_in1, req_in2, resp_ready,
        input  req_ready, resp_valid, resp_out, resp_zero
    );

    modport slave (
        input  req_valid, req_ctrl, req_sign, req_in1, req_in2, resp_ready,
        output req_ready, resp_valid, resp_out, resp_zero
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter (purely combinational).
//   req[1:0] : requests
//   en       : grant enable (downstream can take a new entry)
//   last     : id of the most recently granted requester
//   gnt[1:0] : one-hot grant, all zero when en is low or nothing requests
//   gnt_id   : index of the winner (meaningful when gnt is non-zero)
// The last pointer is owned and updated by the caller.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_id
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        gnt_id = 1'b0;
        gnt    = '0;
        case (req)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;   // tie goes to whoever did not win last
            default: gnt_id = 1'b0;
        endcase
        if (en && (req != '0)) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant feeds an issue register that drives the ALU; a response
// register captures the ALU result. Both stages advance independently so
// one result per cycle flows while the owner keeps resp_ready high.
//   clk, reset_n             : clock, asynchronous active-low reset
//   bus (slave)              : request/response handshakes and data
//   alu_ctrl/sign/in1/in2    : ALU operand drive (zero while issue is empty)
//   alu_out/alu_zero         : ALU result, sampled into the response stage
module alu_arbiter
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    alu_arbiter_if.slave          bus,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_sign,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_zero
);

    // Issue stage
    logic iss_v;
    logic iss_id;
    req_t iss_q;

    // Response stage
    logic              rsp_v;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_zero;

    logic last;

    logic               drain;
    logic               adv;
    logic               acc;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_id;
    logic               accept;
    req_t               sel;

    // Response leaves when its owner takes it; issue moves on when the
    // response slot is empty or emptying; a new request can enter when the
    // issue slot is empty or moving on.
    assign drain = rsp_v & bus.resp_ready[rsp_id];
    assign adv   = iss_v & (~rsp_v | drain);
    assign acc   = ~iss_v | adv;

    rr_arb2 u_arb (
        .req    (bus.req_valid),
        .en     (acc),
        .last   (last),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign accept        = |gnt;
    assign bus.req_ready = gnt;

    always_comb begin
        sel.ctrl = bus.req_ctrl[gnt_id];
        sel.sign = bus.req_sign[gnt_id];
        sel.in1  = bus.req_in1[gnt_id];
        sel.in2  = bus.req_in2[gnt_id];
    end

    // last resets to 1 so requester 0 wins the first tie.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_v  <= 1'b0;
            iss_id <= 1'b0;
            // NOTE: payload registers are reset too; resp_out and the ALU
            // drive must read zero out of reset, not just the valid bits.
            iss_q  <= '0;
            last   <= 1'b1;
        end else if (accept) begin
            iss_v  <= 1'b1;
            iss_id <= gnt_id;
            iss_q  <= sel;
            last   <= gnt_id;
        end else if (adv) begin
            iss_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_v    <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
        end else if (adv) begin
            rsp_v    <= 1'b1;
            rsp_id   <= iss_id;
            rsp_out  <= alu_out;
            rsp_zero <= alu_zero;
        end else if (drain) begin
            rsp_v    <= 1'b0;
        end
    end

    // ALU sees only registered operands; an empty issue slot drives a NOP.
    always_comb begin
        alu_ctrl = NOP;
        alu_sign = 1'b0;
        alu_in1  = '0;
        alu_in2  = '0;
        if (iss_v) begin
            alu_ctrl = iss_q.ctrl;
            alu_sign = iss_q.sign;
            alu_in1  = iss_q.in1;
            alu_in2  = iss_q.in2;
        end
    end

    assign bus.resp_valid = {rsp_v & rsp_id, rsp_v & ~rsp_id};
    assign bus.resp_out   = rsp_out;
    assign bus.resp_zero  = rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A behavioural ALU
// closes the loop on the alu_* ports; accepted requests push their expected
// result into a scoreboard that is popped as responses are consumed.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] out;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    logic [4:0]  alu_ctrl;
    logic        alu_sign;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        alu_zero;

    alu_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .alu_ctrl (alu_ctrl),
        .alu_sign (alu_sign),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        case (c)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            NOR:     return ~(a | b);
            SL:      return a << b[4:0];
            SR:      return s ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            SLT:     return s ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_out  = ref_alu(alu_ctrl, alu_sign, alu_in1, alu_in2);
        alu_zero = (alu_out == 32'h0);
    end

    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];
    int         grant_log[$];
    logic [1:0] acc_seen;
    logic [1:0] rsp_seen;

    task automatic set_req(input int i, input logic [4:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_ctrl[i]  = c;
        bus.req_sign[i]  = s;
        bus.req_in1[i]   = a;
        bus.req_in2[i]   = b;
        bus.req_valid[i] = 1'b1;
    endtask

    // Observe handshakes just before the rising edge, then move to the
    // following falling edge.
    task automatic step();
        exp_t e;
        #1;
        acc_seen = 2'b00;
        rsp_seen = 2'b00;
        checks++;
        if ($countones(bus.req_ready) > 1) begin
            errors++;
            $display("FAIL req_ready_onehot: got %b, need at most one bit set", bus.req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc_seen[i] = 1'b1;
                grant_log.push_back(i);
                e.id   = 1'(i);
                e.out  = ref_alu(bus.req_ctrl[i], bus.req_sign[i], bus.req_in1[i], bus.req_in2[i]);
                e.zero = (e.out == 32'h0);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.resp_valid[i] && bus.resp_ready[i]) begin
                rsp_seen[i] = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got response id=%0d out=%h, need none", i, bus.resp_out);
                end else begin
                    e = sb.pop_front();
                    if (e.id !== 1'(i) || bus.resp_out !== e.out || bus.resp_zero !== e.zero) begin
                        errors++;
                        $display("FAIL resp_data: got id=%0d out=%h zero=%b, need id=%0d out=%h zero=%b",
                                 i, bus.resp_out, bus.resp_zero, e.id, e.out, e.zero);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, need 0", sb.size());
        end
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        repeat (2) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.req_ctrl   = '0;
        bus.req_sign   = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.resp_ready = '0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_zero} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got ready=%b valid=%b out=%h zero=%b, need all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_zero);
        end
        checks++;
        if ({alu_ctrl, alu_sign, alu_in1, alu_in2} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got ctrl=%0d sign=%b in1=%h in2=%h, need all 0",
                     alu_ctrl, alu_sign, alu_in1, alu_in2);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_add();
        bus.resp_ready = 2'b11;
        set_req(0, ADD, 1'b0, 32'd3, 32'd4);
        step();
        bus.req_valid[0] = 1'b0;
        checks++;
        if (acc_seen !== 2'b01) begin
            errors++; $display("FAIL add_accept: got %b, need 01", acc_seen);
        end
        checks++;
        if (alu_ctrl !== ADD || alu_in1 !== 32'd3 || alu_in2 !== 32'd4 || bus.resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL add_issue: got ctrl=%0d in1=%h in2=%h valid=%b, need 1/3/4/00",
                     alu_ctrl, alu_in1, alu_in2, bus.resp_valid);
        end
        step();
        checks++;
        if (bus.resp_valid !== 2'b01 || bus.resp_out !== 32'd7 || bus.resp_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: got valid=%b out=%h zero=%b, need 01/7/0",
                     bus.resp_valid, bus.resp_out, bus.resp_zero);
        end
        drain_all(4);
    endtask

    task automatic test_zero_flag();
        set_req(1, SUB, 1'b0, 32'd5, 32'd5);
        step();
        bus.req_valid[1] = 1'b0;
        checks++;
        if (acc_seen !== 2'b10 || bus.resp_valid !== 2'b00) begin
            errors++; $display("FAIL zero_accept: got acc=%b valid=%b, need 10/00", acc_seen, bus.resp_valid);
        end
        step();
        checks++;
        if (bus.resp_valid !== 2'b10 || bus.resp_out !== 32'd0 || bus.resp_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_resp: got valid=%b out=%h zero=%b, need 10/0/1",
                     bus.resp_valid, bus.resp_out, bus.resp_zero);
        end
        drain_all(4);
        checks++;
        if (bus.resp_valid !== 2'b00) begin
            errors++; $display("FAIL zero_after: got valid=%b, need 00", bus.resp_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 2'b10;
        set_req(0, SLT, 1'b1, 32'hFFFF_FFFF, 32'd1);
        step();
        checks++;
        if (acc_seen !== 2'b01) begin
            errors++; $display("FAIL bp_first_accept: got %b, need 01", acc_seen);
        end
        set_req(0, ADD, 1'b0, 32'd10, 32'd20);
        step();
        bus.req_valid[0] = 1'b0;
        checks++;
        if (acc_seen !== 2'b01) begin
            errors++; $display("FAIL bp_second_accept: got %b, need 01", acc_seen);
        end
        set_req(1, OR, 1'b0, 32'hF0, 32'h0F);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (acc_seen !== 2'b00 || bus.resp_valid !== 2'b01 || bus.resp_out !== 32'd1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got acc=%b valid=%b out=%h, need 00/01/1",
                         k, acc_seen, bus.resp_valid, bus.resp_out);
            end
        end
        bus.resp_ready = 2'b11;
        step();
        bus.req_valid[1] = 1'b0;
        checks++;
        if (acc_seen !== 2'b10 || rsp_seen !== 2'b01) begin
            errors++; $display("FAIL bp_release: got acc=%b rsp=%b, need 10/01", acc_seen, rsp_seen);
        end
        step();
        checks++;
        if (rsp_seen !== 2'b01) begin
            errors++; $display("FAIL bp_back_to_back: got rsp=%b, need 01", rsp_seen);
        end
        drain_all(4);
    endtask

    task automatic test_opcode_passthrough();
        set_req(0, 5'd20, 1'b1, 32'hA, 32'hB);
        step();
        bus.req_valid[0] = 1'b0;
        checks++;
        if (alu_ctrl !== 5'd20 || alu_sign !== 1'b1 || alu_in1 !== 32'hA) begin
            errors++;
            $display("FAIL opcode_pass: got ctrl=%0d sign=%b in1=%h, need 20/1/a", alu_ctrl, alu_sign, alu_in1);
        end
        drain_all(4);
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 2'b00;
        set_req(0, ADD, 1'b0, 32'd1, 32'd1);
        step();
        bus.req_valid[0] = 1'b0;
        set_req(1, SUB, 1'b0, 32'd9, 32'd2);
        step();
        bus.req_valid[1] = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_zero,
             alu_ctrl, alu_sign, alu_in1, alu_in2} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b out=%h ctrl=%0d in1=%h, need all 0",
                     bus.resp_valid, bus.resp_out, alu_ctrl, alu_in1);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n        = 1'b1;
        bus.resp_ready = 2'b11;
        set_req(0, XOR, 1'b0, 32'h55, 32'hFF);
        set_req(1, AND, 1'b0, 32'h55, 32'hFF);
        step();
        bus.req_valid = 2'b00;
        checks++;
        if (acc_seen !== 2'b01 || bus.resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_first: got acc=%b valid=%b, need 01/00", acc_seen, bus.resp_valid);
        end
        drain_all(4);
    endtask

    task automatic test_fairness();
        apply_reset();
        bus.resp_ready = 2'b11;
        set_req(0, ADD, 1'b0, 32'd0, 32'd0);
        set_req(1, ADD, 1'b0, 32'd1, 32'd0);
        grant_log.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc_seen[i]) bus.req_in1[i] = bus.req_in1[i] + 32'd2;
            end
        end
        bus.req_valid = 2'b00;
        drain_all(6);
        checks++;
        if (grant_log.size() != 8) begin
            errors++; $display("FAIL fair_count: got %0d grants, need 8", grant_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (grant_log[k] != k % 2) begin
                    errors++; $display("FAIL fair_order: grant %0d got id %0d, need %0d", k, grant_log[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_idle();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (alu_ctrl !== NOP || alu_sign !== 1'b0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
                errors++;
                $display("FAIL idle_alu: cycle %0d got ctrl=%0d sign=%b in1=%h in2=%h, need all 0",
                         k, alu_ctrl, alu_sign, alu_in1, alu_in2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_zero_flag();
        test_backpressure();
        test_opcode_passthrough();
        test_reset_mid();
        test_fairness();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single ALU instance between two requesters: requester 0 is the main execute path and requester 1 is the address/branch-compare helper. Round-robin arbitration feeds a two-stage pipeline: an issue register drives the ALU, and a response register captures its result. Valid/ready handshakes on both the request and response sides give one-result-per-cycle throughput and full backpressure. The block sits between the requesters and the existing combinational ALU, whose `ALUCtrl`/`Sign`/`in1`/`in2`/`out`/`zero` ports it drives and samples.

## Interface
- `NUM_REQ`, 2: number of requesters. Fixed at 2; no other value is supported.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid[i]` in 1 (i = 0,1): request i presents an operation.
- `req_ready[i]` out 1: request i accepted this cycle.
- `req_ctrl[i]` in 5: ALU opcode (NOP..SLT encoding).
- `req_sign[i]` in 1: signed-operation flag.
- `req_in1[i]`, `req_in2[i]` in 32 each: operands.
- `resp_valid[i]` out 1: result for requester i is available.
- `resp_ready[i]` in 1: requester i consumes the result.
- `resp_out` out 32: shared result bus, meaningful only while the owner's `resp_valid` is high.
- `resp_zero` out 1: zero flag, qualified the same way as `resp_out`.
- `alu_ctrl` out 5, `alu_sign` out 1, `alu_in1` out 32, `alu_in2` out 32: drive the ALU.
- `alu_out` in 32, `alu_zero` in 1: ALU result.

## Operation
- **State:** issue stage (`iss_v`, `iss_id`, ctrl/sign/in1/in2), response stage (`rsp_v`, `rsp_id`, out/zero), and a round-robin pointer `last` (id of the last granted requester).
- **Drain:** `drain = rsp_v & resp_ready[rsp_id]`.
- **Advance:** `adv = iss_v & (!rsp_v | drain)`.
- **Accept:** `acc = !iss_v | adv`.
- **Grant:**
  - Only one valid requester: it is granted.
  - Both valid: the requester not equal to `last` is granted.
  - `req_ready[g] = acc & req_valid[g]`. `req_ready` is never high for more than one requester.
- **Accept edge:** on a cycle with an accepted request, load the issue stage, set `iss_id = g`, and set `last = g`.
- **Issue idle:**
  - If `acc` is high and no request is accepted, `iss_v` clears on `adv`.
  - While `iss_v` is low, the ALU is driven with ctrl=0 (NOP), sign=0, in1=0, in2=0.
- **ALU drive:** while `iss_v` is high, the ALU is driven directly from the issue registers. There is no combinational path from `req_*` to `alu_*`.
- **Response stage:**
  - On `adv`, load `rsp_out = alu_out`, `rsp_zero = alu_zero`, `rsp_id = iss_id`, and set `rsp_v = 1`.
  - Otherwise, on `drain`, clear `rsp_v`.
- **Response outputs:** `resp_valid[i] = rsp_v & (rsp_id == i)`.
- **Opcode handling:** opcodes are passed through unmodified. Values above SLT are forwarded as-is, and the ALU behaviour for them is undefined.
- **Fairness:** a requester held valid is granted within 2 accepting cycles.

## Timing
- **Reset values:**
  - `req_ready` = 0, `resp_valid` = 0, `resp_out` = 0, `resp_zero` = 0.
  - `alu_ctrl` = 0, `alu_sign` = 0, `alu_in1` = 0, `alu_in2` = 0.
  - `last` = 1, so requester 0 wins the first tie.
- **Latency:** a request accepted at edge E0 has its ALU operands on `alu_*` during the cycle after E0, and `resp_valid` high after edge E1 (2 edges).
- **Throughput:** 1 op/cycle while the owner holds `resp_ready` high.
- **Full pipeline:** when `rsp_v` is set and not draining, and `iss_v` is set, `req_ready` = 0 for both requesters. Issue and response registers hold their values.
- **Simultaneous drain, advance and accept:** all three occur on the same edge, with no bubble.
- **Reset mid-operation:** any in-flight issue or response entry is discarded with no response. After `reset_n` deasserts, the first accept is possible on the first rising edge.
- **Request stability:** a requester must hold its `req_*` signals stable while `req_valid` is high and `req_ready` is low. Withdrawing `req_valid` before a grant is legal.

## Structure
- **Package `alu_pkg`:**
  - `ALU_CTRL_W` = 5.
  - Opcode constants: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6, SL=7, SR=8, SLT=9.
  - `NUM_REQ` = 2.
  - A request struct type {ctrl, sign, in1, in2}.
- **Sub-module `rr_arb2`:** two-input round-robin arbiter with inputs `req[1:0]`, `en`, and `last`, and outputs a one-hot `gnt` and `gnt_id`. The `last` pointer update stays in `alu_arbiter`.

## Test plan
- **Single ADD:** requester 0 sends ADD, in1=3, in2=4, `resp_ready`=1 → `resp_valid[0]` 2 edges after accept, with `resp_out`=7 and `resp_zero`=0.
- **Zero flag:** requester 1 sends SUB, 5−5 → `resp_valid[1]`=1, `resp_out`=0, `resp_zero`=1. `resp_valid[0]` stays 0 throughout.
- **Fairness under contention:** both requesters continuously valid with ADD (in1=i, in2=0) → grants alternate 0,1,0,1…, starting with requester 0 after reset, and responses return in grant order.
- **Backpressure:** SLT signed with in1=0xFFFFFFFF, in2=1, and `resp_ready[0]`=0 for 5 cycles → `resp_out`=1 is held stable. A second request is accepted into issue, then `req_ready`=0 until the drain. On release, both results are delivered back-to-back.
- **Reset mid-operation:** assert `reset_n`=0 while both stages are valid → all outputs go to 0 immediately (asynchronously). After release, no stale `resp_valid` appears, and requester 0 wins the first tie.
- **Idle ALU drive:** no requests for 3 cycles → `alu_ctrl`=0 and `alu_in1`=`alu_in2`=0 on each cycle.
